// File: rtl/cla_seq_pkg.sv
// Shared types and defaults for the multi-precision CLA sequencer.
// Holds the FSM state enum, default slice geometry and the total-width helper.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WORD_W = 9;
  localparam int unsigned DEF_NWORDS = 4;

  function automatic int unsigned calc_tw(input int unsigned word_w, input int unsigned nwords);
    return word_w * nwords;
  endfunction

endpackage

// File: rtl/cla_seq_ctrl.sv
// Multi-word add/subtract sequencer time-sharing one external WORD_W-bit CLA adder.
// Define CLA_SEQ_SUB_EN to honour op_sub (a - b as a + ~b + 1); otherwise every op is a + b + cin.
module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter  int unsigned WORD_W = DEF_WORD_W,
  parameter  int unsigned NWORDS = DEF_NWORDS,
  localparam int unsigned TW     = calc_tw(WORD_W, NWORDS),
  localparam int unsigned IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TW-1:0]     op_a,
  input  logic [TW-1:0]     op_b,
  input  logic              op_cin,
  input  logic              op_sub,
  output logic [WORD_W-1:0] adder_a,
  output logic [WORD_W-1:0] adder_b,
  output logic              adder_cin,
  input  logic [WORD_W-1:0] adder_sum,
  input  logic              adder_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TW-1:0]     result,
  output logic              cout,
  output logic              overflow
);

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_a;
  logic [TW-1:0]   r_b_eff;
  logic [TW-1:0]   r_result;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;
  logic            w_accept;
  logic            w_last;
  logic [TW-1:0]   w_b_in;
  logic            w_cin_in;

`ifdef CLA_SEQ_SUB_EN
  assign w_b_in   = op_sub ? ~op_b : op_b;
  assign w_cin_in = op_sub ? 1'b1  : op_cin;
`else
  logic w_unused_sub;
  assign w_unused_sub = op_sub;
  assign w_b_in       = op_b;
  assign w_cin_in     = op_cin;
`endif

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_idx == IW'(NWORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (r_state == RUN) begin
      adder_a   = r_a[r_idx*WORD_W +: WORD_W];
      adder_b   = r_b_eff[r_idx*WORD_W +: WORD_W];
      adder_cin = r_carry;
    end
  end

  // Sign of the full result is the MSB of the last slice sum, captured on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b_eff  <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b_eff <= w_b_in;
      r_carry <= w_cin_in;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_result[r_idx*WORD_W +: WORD_W] <= adder_sum;
      r_carry                          <= adder_cout;
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= adder_cout;
        r_ovf  <= (r_a[TW-1] == r_b_eff[TW-1]) && (adder_sum[WORD_W-1] != r_a[TW-1]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Self-checking bench for cla_seq_ctrl with a behavioural adder and a whole-word arithmetic reference model.
module tb_cla_seq_ctrl;

  localparam int unsigned WW = 9;
  localparam int unsigned NW = 4;
  localparam int unsigned TW = WW * NW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] op_a = '0;
  logic [TW-1:0] op_b = '0;
  logic          op_cin = 1'b0;
  logic          op_sub = 1'b0;
  logic [WW-1:0] adder_a, adder_b, adder_sum;
  logic          adder_cin, adder_cout;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW-1:0] result;
  logic          cout, overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{WW{1'b0}}, adder_cin};

  cla_seq_ctrl #(.WORD_W(WW), .NWORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow)
  );

  // Reference: plain integer arithmetic on the whole operands.
  function automatic void model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                input logic cin, input logic sub,
                                output logic [TW-1:0] r, output logic co, output logic ov);
    logic [TW:0] full;
    longint sa, sb, s;
    bit do_sub;
    sa = $signed(a);
    sb = $signed(b);
`ifdef CLA_SEQ_SUB_EN
    do_sub = sub;
`else
    do_sub = 1'b0;
`endif
    if (do_sub) begin
      full = {1'b0, a} - {1'b0, b};
      co   = (a >= b);
      s    = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};
      co   = full[TW];
      s    = sa + sb + longint'(cin);
    end
    r  = full[TW-1:0];
    ov = (s > 64'sd34359738367) || (s < -64'sd34359738368);
  endfunction

  task automatic send_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic cin, input logic sub, output bit ok);
    int unsigned n = 0;
    @(negedge clk);
    op_a = a; op_b = b; op_cin = cin; op_sub = sub; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = ~a; op_b = ~b; op_cin = ~cin; op_sub = ~sub;
  endtask

  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ok = out_valid;
  endtask

  task automatic take_out(input int unsigned delay);
    repeat (delay) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, result, cout, overflow, adder_a, adder_b, adder_cin} !==
        {1'b1, 1'b0, {TW{1'b0}}, 1'b0, 1'b0, {WW{1'b0}}, {WW{1'b0}}, 1'b0})
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h co=%b ov=%b aa=%h ab=%h ac=%b exp rdy=1 others 0",
               in_ready, out_valid, result, cout, overflow, adder_a, adder_b, adder_cin);
    if ({in_ready, out_valid, result, cout, overflow, adder_a, adder_b, adder_cin} !==
        {1'b1, 1'b0, {TW{1'b0}}, 1'b0, 1'b0, {WW{1'b0}}, {WW{1'b0}}, 1'b0}) n_errors++;
    rst_n = 1'b1;
  endtask

  typedef struct {
    string         name;
    logic [TW-1:0] a, b;
    logic          cin, sub;
    logic [TW-1:0] r;
    logic          co, ov;
  } vec_t;

  task automatic test_directed();
    vec_t v[4];
    bit ok;
    int lat;
    v[0] = '{"cross_carry", 36'h0000001FF, 36'h000000001, 1'b0, 1'b0, 36'h000000200, 1'b0, 1'b0};
    v[1] = '{"full_ripple", 36'hFFFFFFFFF, 36'h000000000, 1'b1, 1'b0, 36'h000000000, 1'b1, 1'b0};
    v[2] = '{"signed_ovf",  36'h7FFFFFFFF, 36'h000000001, 1'b0, 1'b0, 36'h800000000, 1'b0, 1'b1};
`ifdef CLA_SEQ_SUB_EN
    v[3] = '{"subtract",    36'h000000005, 36'h000000007, 1'b0, 1'b1, 36'hFFFFFFFFE, 1'b0, 1'b0};
`else
    v[3] = '{"sub_ignored", 36'h000000005, 36'h000000007, 1'b0, 1'b1, 36'h00000000C, 1'b0, 1'b0};
`endif
    foreach (v[i]) begin
      send_op(v[i].a, v[i].b, v[i].cin, v[i].sub, ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL %s_accept: in_ready got 0 exp 1", v[i].name); end
      wait_out(lat, ok);
      n_checks++;
      if (lat !== NW) begin n_errors++; $display("FAIL %s_latency: got %0d exp %0d", v[i].name, lat, NW); end
      n_checks++;
      if (result !== v[i].r) begin n_errors++; $display("FAIL %s_result: got %h exp %h", v[i].name, result, v[i].r); end
      n_checks++;
      if (cout !== v[i].co) begin n_errors++; $display("FAIL %s_cout: got %b exp %b", v[i].name, cout, v[i].co); end
      n_checks++;
      if (overflow !== v[i].ov) begin n_errors++; $display("FAIL %s_ovf: got %b exp %b", v[i].name, overflow, v[i].ov); end
      take_out(0);
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_errors++; $display("FAIL %s_release: got rdy/vld=%b exp 10", v[i].name, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] a, b, er;
    logic eco, eov;
    bit ok;
    int lat;
    a = 36'h123456789;
    b = 36'h0FEDCBA98;
    model(a, b, 1'b1, 1'b0, er, eco, eov);
    send_op(a, b, 1'b1, 1'b0, ok);
    wait_out(lat, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL bp_timeout: out_valid got 0 exp 1"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op_a = {$urandom(), $urandom()};
      op_b = {$urandom(), $urandom()};
      op_cin = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, result, cout, overflow} !== {1'b0, 1'b1, er, eco, eov}) begin
        n_errors++;
        $display("FAIL bp_hold_%0d: got rdy=%b vld=%b res=%h co=%b ov=%b exp rdy=0 vld=1 res=%h co=%b ov=%b",
                 i, in_ready, out_valid, result, cout, overflow, er, eco, eov);
      end
    end
    in_valid = 1'b0;
    take_out(0);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_errors++; $display("FAIL bp_release: got rdy/vld=%b exp 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int lat;
    send_op(36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b1, 1'b0, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, result, cout, overflow, adder_a, adder_b, adder_cin} !==
        {1'b1, 1'b0, {TW{1'b0}}, 1'b0, 1'b0, {WW{1'b0}}, {WW{1'b0}}, 1'b0}) begin
      n_errors++;
      $display("FAIL midrun_reset: got rdy=%b vld=%b res=%h co=%b ov=%b aa=%h ab=%h ac=%b exp rdy=1 others 0",
               in_ready, out_valid, result, cout, overflow, adder_a, adder_b, adder_cin);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_op(36'd3, 36'd4, 1'b0, 1'b0, ok);
    wait_out(lat, ok);
    n_checks++;
    if ({ok, result, cout, overflow} !== {1'b1, 36'd7, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL after_reset_op: got vld=%b res=%h co=%b ov=%b exp vld=1 res=%h co=0 ov=0",
               ok, result, cout, overflow, 36'd7);
    end
    take_out(0);
  endtask

  task automatic test_random();
    logic [TW-1:0] a, b, er;
    logic cin, sub, eco, eov;
    bit ok;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      a   = {$urandom(), $urandom()};
      b   = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) b = ~a;
      cin = 1'($urandom());
      sub = 1'($urandom());
      model(a, b, cin, sub, er, eco, eov);
      send_op(a, b, cin, sub, ok);
      wait_out(lat, ok);
      n_checks++;
      if ({ok, result, cout, overflow} !== {1'b1, er, eco, eov}) begin
        n_errors++;
        $display("FAIL rand_%0d a=%h b=%h cin=%b sub=%b: got vld=%b res=%h co=%b ov=%b exp vld=1 res=%h co=%b ov=%b",
                 i, a, b, cin, sub, ok, result, cout, overflow, er, eco, eov);
      end
      take_out($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cla_seq_ctrl.md
# cla_seq_ctrl

Multi-precision add/subtract sequencer that time-shares one external WORD_W-bit CLA adder to produce NWORDS*WORD_W-bit results. It accepts wide operands over a valid/ready handshake and drives the adder one word per cycle, least-significant word first, chaining the carry in a register. It then presents the result, carry-out and signed overflow over a second valid/ready handshake. It sits between the ALU operand registers and the shared CLA_Adder instance.

## Interface
- WORD_W, 9: width of the shared adder slice
- NWORDS, 4: words per operand; total width TW = NWORDS*WORD_W (36 by default)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  high only in IDLE
- op_a, op_b  in  TW  operands, sampled at accept
- op_cin  in  1  carry-in for add
- op_sub  in  1  subtract request (see Configuration)
- adder_a, adder_b  out  WORD_W  slice operands to shared adder
- adder_cin  out  1  slice carry-in
- adder_sum  in  WORD_W  slice sum, combinational from adder
- adder_cout  in  1  slice carry-out
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  TW  sum/difference
- cout  out  1  final carry (subtract: 1 = no borrow)
- overflow  out  1  two's-complement overflow of TW-bit result

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - in_valid && in_ready: latch op_a, op_b and sub_r.
  - b_eff = sub_r ? ~op_b : op_b.
  - carry_r = sub_r ? 1 : op_cin.
  - idx=0 → RUN.
- RUN: drive adder with adder_a=a_r[idx], adder_b=b_eff[idx], adder_cin=carry_r.
  - Each cycle: result[idx] <= adder_sum, carry_r <= adder_cout, idx++.
  - At idx==NWORDS-1, the same edge captures the last word, computes cout and overflow → DONE.
- overflow = (a_r MSB == b_eff MSB) && (sum MSB != a_r MSB).
- DONE: out_valid=1; result, cout and overflow held stable until out_ready is sampled high → IDLE.
- Outside RUN: adder_a, adder_b and adder_cin drive 0.
- idx width is clog2(NWORDS); NWORDS=1 is legal (RUN lasts one cycle).
- Arithmetic is modulo 2^TW; carry out of word NWORDS-1 goes only to cout.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, result=0, cout=0, overflow=0, adder_* = 0, idx=0, carry_r=0.
- Latency: accept on edge k → out_valid high after edge k+NWORDS (4 cycles default). Throughput is one operation per NWORDS+2 cycles minimum.
- in_valid in RUN or DONE: ignored, in_ready=0, operands not sampled.
- out_ready low in DONE: state and outputs hold indefinitely.
- out_valid && out_ready in DONE: IDLE next cycle; there is no same-cycle re-accept.
- out_ready while not in DONE: ignored.
- rst_n asserted at any time, including mid-RUN: the operation is immediately aborted and all outputs return to reset values. No partial result is ever presented.
- The adder path is combinational within one cycle; the timing budget is the WORD_W-bit CLA delay plus mux plus register setup.

## Configuration
- CLA_SEQ_SUB_EN defined:
  - op_sub honoured.
  - Subtract computes op_a - op_b as op_a + ~op_b + 1; op_cin is ignored.
- CLA_SEQ_SUB_EN undefined:
  - op_sub is ignored and sub_r logic is removed.
  - All operations are op_a + op_b + op_cin.

## Structure
- Package cla_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default WORD_W and NWORDS constants;
  - a localparam function for TW.
- Single module, no sub-module. The CLA adder stays external so other ALU paths can share it.

## Test plan
- Cross-word carry: a=36'h0000001FF, b=36'h000000001, cin=0 → result=36'h000000200, cout=0, overflow=0, out_valid exactly 4 cycles after accept.
- Full ripple: a=36'hFFFFFFFFF, b=0, cin=1 → result=0, cout=1, overflow=0.
- Signed overflow: a=36'h7FFFFFFFF, b=1, cin=0 → result=36'h800000000, overflow=1.
- Subtract (CLA_SEQ_SUB_EN): a=5, b=7, sub=1 → result=36'hFFFFFFFFE, cout=0, overflow=0.
  - Without the macro, the same stimulus gives result=12.
- Backpressure: hold out_ready=0 for 5 cycles and pulse in_valid with new operands → result stable, in_ready=0, new operands not captured; result accepted on the first out_ready.
- Reset mid-RUN (idx=2) → all outputs at reset values; a following a=3, b=4 operation yields 7. Then run 1000 random operations checked against a+b+cin (mod 2^36) for result, cout and overflow.
